fios_res_collector: RTL and testbench

- Sits at the output end of the FIOS PE chain and receives the 17-bit result words that the last PE streams out on RES_o, least-significant word first.
- Buffers the full result and, in parallel, computes result minus p word-serially with a borrow chain.
- Applies the final Montgomery conditional subtraction, so the reduced result is less than p.
- Replays the reduced result word-serially to the downstream consumer over a valid/ready handshake.

---
 rtl/fios_res_collector.sv | 136 +++++++++++++
 tb/tb_fios_res_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fios_res_collector.sv
// Purpose: collects the FIOS result words, forms result - p in parallel and emits the reduced value.
// Latency: out_valid_o rises two cycles after the cycle that carries the last input word.
// Backpressure: out_ready_i low holds out_word_o/out_last_o; input side has no ready (res_valid_i only).
//
// Ports:
//   clock_i, reset_n_i         clock, asynchronous active-low reset
//   start_i                    arms a new collection (IDLE only)
//   res_valid_i/res_i/p_i      result and modulus words in lockstep, LSW first
//   res_msb_i                  overflow bit above the top word, sampled with the last word
//   out_valid_o/out_ready_i    output handshake; out_word_o LSW first, out_last_o on the top word
//   sub_applied_o              p was subtracted (stable from DECIDE until the next start)
//   busy_o, done_o             not idle; one-cycle pulse after the final output handshake
module fios_res_collector #(
  parameter int WORD_WIDTH = 17,
  parameter int WORD_COUNT = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  res_valid_i,
  input  logic [WORD_WIDTH-1:0] res_i,
  input  logic [WORD_WIDTH-1:0] p_i,
  input  logic                  res_msb_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [WORD_WIDTH-1:0] out_word_o,
  output logic                  out_last_o,
  output logic                  sub_applied_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   borrow_q;
  logic                   msb_q;
  logic [WORD_WIDTH-1:0]  res_buf  [WORD_COUNT];
  logic [WORD_WIDTH-1:0]  diff_buf [WORD_COUNT];
  logic [WORD_WIDTH:0]    sub_full;
  logic                   decide_sel;
  logic [WORD_WIDTH-1:0]  next_word;

  // One step of the word-serial borrow chain; the top bit is the outgoing borrow.
  assign sub_full = {1'b0, res_i} - {1'b0, p_i} - {{WORD_WIDTH{1'b0}}, borrow_q};

  // An overflow bit means the result exceeds 2^(W*N) > p, so the final borrow is ignored.
  assign decide_sel = msb_q | ~borrow_q;

  assign idx_nxt   = idx_q + 1'b1;
  assign next_word = sub_applied_o ? diff_buf[idx_nxt] : res_buf[idx_nxt];

  // Buffers carry no reset: their contents are only read after a full collection.
  always_ff @(posedge clock_i) begin
    if (state_q == COLLECT && res_valid_i) begin
      res_buf[idx_q]  <= res_i;
      diff_buf[idx_q] <= sub_full[WORD_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      borrow_q      <= 1'b0;
      msb_q         <= 1'b0;
      out_valid_o   <= 1'b0;
      out_word_o    <= '0;
      out_last_o    <= 1'b0;
      sub_applied_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_q         <= '0;
            borrow_q      <= 1'b0;
            sub_applied_o <= 1'b0;
            busy_o        <= 1'b1;
            state_q       <= COLLECT;
          end
        end
        COLLECT: begin
          if (res_valid_i) begin
            borrow_q <= sub_full[WORD_WIDTH];
            idx_q    <= idx_nxt;
            if (idx_q == LAST_IDX) begin
              msb_q   <= res_msb_i;
              state_q <= DECIDE;
            end
          end
        end
        DECIDE: begin
          // Word 0 is preloaded here so out_valid_o rises with valid data.
          sub_applied_o <= decide_sel;
          idx_q         <= '0;
          out_valid_o   <= 1'b1;
          out_word_o    <= decide_sel ? diff_buf[0] : res_buf[0];
          out_last_o    <= (LAST_IDX == '0);
          state_q       <= EMIT;
        end
        EMIT: begin
          if (out_ready_i) begin
            if (idx_q == LAST_IDX) begin
              out_valid_o <= 1'b0;
              out_word_o  <= '0;
              out_last_o  <= 1'b0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              idx_q       <= '0;
              state_q     <= IDLE;
            end else begin
              idx_q      <= idx_nxt;
              out_word_o <= next_word;
              out_last_o <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_res_collector.sv
module tb_fios_res_collector;
  localparam int W  = 17;
  localparam int N  = 8;
  localparam int TW = W * N;

  logic          clock_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          res_valid_i = 1'b0;
  logic [W-1:0]  res_i = '0;
  logic [W-1:0]  p_i = '0;
  logic          res_msb_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic          out_valid_o;
  logic [W-1:0]  out_word_o;
  logic          out_last_o;
  logic          sub_applied_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  fios_res_collector #(.WORD_WIDTH(W), .WORD_COUNT(N)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .res_valid_i(res_valid_i), .res_i(res_i), .p_i(p_i), .res_msb_i(res_msb_i),
    .out_ready_i(out_ready_i), .out_valid_o(out_valid_o), .out_word_o(out_word_o),
    .out_last_o(out_last_o), .sub_applied_o(sub_applied_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_wide();
    logic [TW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // One full operation. Expected words come from plain wide arithmetic on the operands.
  task automatic run(input logic [TW-1:0] res, input logic [TW-1:0] p, input logic msb,
                     input int max_gap, input int stall_at, input bit poke_start, input bit junk_start);
    logic [TW:0] full;
    logic [TW:0] red;
    logic        exp_sub;
    int          hs;
    int          stall_left;
    int          budget;
    full    = {msb, res};
    exp_sub = (full >= {1'b0, p});
    red     = exp_sub ? full - {1'b0, p} : full;
    for (int i = 0; i < N; i++) exp_q.push_back(red[i*W +: W]);

    @(negedge clock_i);
    start_i = 1'b1;
    if (junk_start) begin
      res_valid_i = 1'b1; res_i = W'($urandom); p_i = W'($urandom);
    end
    @(negedge clock_i);
    start_i = 1'b0; res_valid_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("sub_cleared_on_start", 32'(sub_applied_o), 32'd0);

    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        res_valid_i = 1'b0; res_i = W'($urandom); p_i = W'($urandom);
        @(negedge clock_i);
      end
      res_valid_i = 1'b1;
      res_i = res[i*W +: W];
      p_i   = p[i*W +: W];
      res_msb_i = (i == N - 1) ? msb : 1'($urandom);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    chk("valid_low_in_decide", 32'(out_valid_o), 32'd0);
    @(negedge clock_i);
    chk("valid_rise_latency", 32'(out_valid_o), 32'd1);
    chk("sub_applied", 32'(sub_applied_o), 32'(exp_sub));

    hs = 0; stall_left = 3; budget = 0;
    while (hs < N && budget < 200) begin
      budget++;
      out_ready_i = !(hs == stall_at && stall_left > 0);
      start_i = (poke_start && hs == 2);
      if (out_valid_o) begin
        chk("out_word", 32'(out_word_o), 32'(exp_q[0]));
        chk("out_last", 32'(out_last_o), 32'(hs == N - 1));
        chk("done_low_during_emit", 32'(done_o), 32'd0);
        if (out_ready_i) begin
          void'(exp_q.pop_front());
          hs++;
        end else begin
          stall_left--;
        end
      end
      @(negedge clock_i);
    end
    out_ready_i = 1'b0; start_i = 1'b0;
    chk("handshake_count", 32'(hs), 32'(N));
    exp_q.delete();
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("valid_drop", 32'(out_valid_o), 32'd0);
    @(negedge clock_i);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("idle_after_done", 32'(busy_o), 32'd0);
    chk("sub_held", 32'(sub_applied_o), 32'(exp_sub));
  endtask

  initial begin
    logic [TW-1:0] p;
    logic [TW-1:0] r;
    logic [TW-1:0] k;
    logic [TW:0]   sum;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_word", 32'(out_word_o), 32'd0);
    chk("rst_sub", 32'(sub_applied_o), 32'd0);
    reset_n_i = 1'b1;
    out_ready_i = 1'b0;

    // res < p: no subtraction
    p = '0; p[0 +: W] = W'(1); p[W +: W] = W'('h10000);
    r = '0; r[W +: W] = W'('h0FFFF);
    run(r, p, 1'b0, 0, -1, 1'b0, 1'b0);

    // res == p: result zero, subtraction selected
    run(p, p, 1'b0, 1, -1, 1'b0, 1'b0);

    // overflow bit set: 2^(W*N) - 1 emitted as all-ones words
    p = '0; p[0 +: W] = W'(1);
    run('0, p, 1'b1, 0, -1, 1'b0, 1'b0);

    // res_valid_i in IDLE is ignored
    @(negedge clock_i);
    res_valid_i = 1'b1; res_i = W'($urandom); p_i = W'($urandom);
    @(negedge clock_i);
    res_valid_i = 1'b0;
    chk("idle_ignores_valid", 32'(busy_o), 32'd0);

    // Random p, res = p + k with k < p, gaps 0..3; includes stall, start poke, start+valid drop
    for (int t = 0; t < 5; t++) begin
      p = rand_wide();
      if (t == 1) p[TW-1] = 1'b1;
      if (p[TW-1 -: W] == '0) p[TW-1 -: W] = W'(1);
      k = rand_wide() % p;
      sum = {1'b0, p} + {1'b0, k};
      r = sum[TW-1:0];
      run(r, p, sum[TW], 3, (t == 2) ? 3 : -1, t == 3, t == 4);
    end

    // Asynchronous reset mid-collection, then a clean run
    p = rand_wide(); p[TW-1] = 1'b1;
    run(p, p, 1'b0, 0, -1, 1'b0, 1'b0);
    @(negedge clock_i);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_valid_i = 1'b1; res_i = W'($urandom); p_i = W'($urandom);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_sub", 32'(sub_applied_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_last", 32'(out_last_o), 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);
    chk("no_output_after_abort", 32'(out_valid_o), 32'd0);
    p = rand_wide(); p[TW-1] = 1'b1;
    k = rand_wide() % p;
    sum = {1'b0, p} + {1'b0, k};
    run(sum[TW-1:0], p, sum[TW], 2, 5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
